// File: rtl/calc1_req_arbiter.sv
// Four-port request capture and round-robin sequencer in front of one calc1 ALU.
// Optional build macro CALC1_CMD_CHECK_EN rejects unsupported commands locally with resp 2.
module calc1_req_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [1:0]        out1_resp,
    output logic [DATA_W-1:0] out1_data,
    output logic [1:0]        out2_resp,
    output logic [DATA_W-1:0] out2_data,
    output logic [1:0]        out3_resp,
    output logic [DATA_W-1:0] out3_data,
    output logic [1:0]        out4_resp,
    output logic [DATA_W-1:0] out4_data,
    output logic              alu_valid,
    output logic [3:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic              alu_done,
    input  logic [1:0]        alu_resp,
    input  logic [DATA_W-1:0] alu_data
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND} port_state_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arb_state_t;

    logic [3:0]        cmd_in  [4];
    logic [DATA_W-1:0] data_in [4];

    port_state_t       pst  [4];
    logic [3:0]        pcmd [4];
    logic [DATA_W-1:0] pop1 [4];
    logic [DATA_W-1:0] pop2 [4];

    arb_state_t        state;
    logic [1:0]        grant;
    logic [1:0]        rr;
    logic [CW-1:0]     cnt;
    logic [1:0]        resp_q [4];
    logic [DATA_W-1:0] data_q [4];

    logic              found;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic              bad_cmd;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign out1_resp = resp_q[0];
    assign out2_resp = resp_q[1];
    assign out3_resp = resp_q[2];
    assign out4_resp = resp_q[3];
    assign out1_data = data_q[0];
    assign out2_data = data_q[1];
    assign out3_data = data_q[2];
    assign out4_data = data_q[3];

    // First pending port at or after the round-robin pointer, wrapping 4 -> 1.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        idx   = rr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!found && pst[idx] == P_PEND) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
`ifdef CALC1_CMD_CHECK_EN
        bad_cmd = !(pcmd[pick] inside {4'd1, 4'd2, 4'd5, 4'd6});
`else
        bad_cmd = 1'b0;
`endif
    end

    always_ff @(posedge c_clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (reset) begin
                pst[i]  <= P_IDLE;
                pcmd[i] <= '0;
                pop1[i] <= '0;
                pop2[i] <= '0;
            end else begin
                case (pst[i])
                    P_IDLE: begin
                        if (cmd_in[i] != 4'd0) begin
                            pcmd[i] <= cmd_in[i];
                            pop1[i] <= data_in[i];
                            pst[i]  <= P_OP2;
                        end
                    end
                    P_OP2: begin
                        pop2[i] <= data_in[i];
                        pst[i]  <= P_PEND;
                    end
                    P_PEND: begin
                        if (state == RESPOND && grant == 2'(i))
                            pst[i] <= P_IDLE;
                    end
                    default: pst[i] <= P_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr        <= '0;
            cnt       <= '0;
            alu_valid <= 1'b0;
            alu_cmd   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                resp_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Responses and the issue strobe are single-cycle pulses; only the
            // transitions below raise them.
            alu_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                resp_q[i] <= '0;
                data_q[i] <= '0;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        rr    <= pick + 2'd1;
                        cnt   <= '0;
                        if (bad_cmd) begin
                            resp_q[pick] <= 2'd2;
                            state        <= RESPOND;
                        end else begin
                            alu_valid <= 1'b1;
                            alu_cmd   <= pcmd[pick];
                            alu_op1   <= pop1[pick];
                            alu_op2   <= pop2[pick];
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        resp_q[grant] <= alu_resp;
                        data_q[grant] <= (alu_resp == 2'd0) ? '0 : alu_data;
                        state         <= RESPOND;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        resp_q[grant] <= 2'd3;
                        state         <= RESPOND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
